// File: rtl/affine_stream_engine.sv
// affine_stream_engine
// ---------------------------------------------------------------------------
// Streaming 2-D affine transform:
//   out_x = a*x + b*y + tx
//   out_y = d*x + e*y + ty
// a/b/d/e are signed Q(WIDTH-FRAC).FRAC, tx/ty/x/y are signed integers.
// Points enter through an input FIFO, pass through a five-state engine
// (IDLE, MUL1, MUL2, SUM, PUSH) and leave through an output FIFO.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cfg_a/b/d/e, cfg_tx/ty    coefficients and offsets, snapshot at pop
//   cfg_round                 1 = round half up, 0 = floor
//   cfg_sat                   1 = saturate, 0 = wrap to WIDTH bits
//   enable                    allows the engine to pop new points
//   flush                     empties both FIFOs, aborts the in-flight point
//   clear_ovf                 clears the sticky overflow flag
//   in_valid/in_ready/in_x/in_y       input point stream
//   out_valid/out_ready/out_x/out_y   output result stream
//   in_count, out_count       FIFO occupancies
//   busy                      engine is not IDLE
//   done                      one-cycle pulse when a result enters the output FIFO
//   overflow                  sticky: some result fell outside the WIDTH range
//   state_dbg                 current engine state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and data is held while valid is
// high and ready is low. During a flush cycle neither port transfers.

module affine_stream_engine #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             cfg_a,
    input  logic [WIDTH-1:0]             cfg_b,
    input  logic [WIDTH-1:0]             cfg_d,
    input  logic [WIDTH-1:0]             cfg_e,
    input  logic [WIDTH-1:0]             cfg_tx,
    input  logic [WIDTH-1:0]             cfg_ty,
    input  logic                         cfg_round,
    input  logic                         cfg_sat,
    input  logic                         enable,
    input  logic                         flush,
    input  logic                         clear_ovf,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             in_x,
    input  logic [WIDTH-1:0]             in_y,
    output logic                         in_ready,
    output logic                         out_valid,
    output logic [WIDTH-1:0]             out_x,
    output logic [WIDTH-1:0]             out_y,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH+1)-1:0]   in_count,
    output logic [$clog2(DEPTH+1)-1:0]   out_count,
    output logic                         busy,
    output logic                         done,
    output logic                         overflow,
    output logic [2:0]                   state_dbg
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = 2*WIDTH;
    localparam int SW = 2*WIDTH+2;

    // Representable output range, sign-extended to the sum width.
    localparam logic signed [SW-1:0] MAX_V = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0] MIN_V = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL1 = 3'd1,
        MUL2 = 3'd2,
        SUM  = 3'd3,
        PUSH = 3'd4
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] in_mem_x [DEPTH];
    logic [WIDTH-1:0] in_mem_y [DEPTH];
    logic [AW-1:0]    in_wr, in_rd;
    logic             in_push, in_pop, start;

    assign in_ready = (in_count != CW'(DEPTH));
    // Output space is reserved here: only one point is ever in flight, so a
    // free output slot at pop time is still free when PUSH arrives.
    assign start    = enable && (in_count != '0) && (out_count < CW'(DEPTH));
    assign in_push  = in_valid && in_ready && !flush;
    assign in_pop   = (state == IDLE) && start && !flush;

    always_ff @(posedge clk) begin
        if (in_push) begin
            in_mem_x[in_wr] <= in_x;
            in_mem_y[in_wr] <= in_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            in_wr    <= '0;
            in_rd    <= '0;
            in_count <= '0;
        end else begin
            if (in_push) in_wr <= in_wr + 1'b1;
            if (in_pop)  in_rd <= in_rd + 1'b1;
            if (in_push && !in_pop)      in_count <= in_count + 1'b1;
            else if (!in_push && in_pop) in_count <= in_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_mem_x [DEPTH];
    logic [WIDTH-1:0] out_mem_y [DEPTH];
    logic [AW-1:0]    out_wr, out_rd;
    logic             out_push, out_pop;
    logic [WIDTH-1:0] res_x, res_y;
    logic             res_ovf;

    assign out_valid = (out_count != '0);
    assign out_push  = (state == PUSH) && !flush;
    assign out_pop   = out_valid && out_ready && !flush;
    assign out_x     = out_valid ? out_mem_x[out_rd] : '0;
    assign out_y     = out_valid ? out_mem_y[out_rd] : '0;

    always_ff @(posedge clk) begin
        if (out_push) begin
            out_mem_x[out_wr] <= res_x;
            out_mem_y[out_wr] <= res_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            out_wr    <= '0;
            out_rd    <= '0;
            out_count <= '0;
        end else begin
            if (out_push) out_wr <= out_wr + 1'b1;
            if (out_pop)  out_rd <= out_rd + 1'b1;
            if (out_push && !out_pop)      out_count <= out_count + 1'b1;
            else if (!out_push && out_pop) out_count <= out_count - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic signed [WIDTH-1:0] a_r, b_r, d_r, e_r, tx_r, ty_r, x_r, y_r;
    logic                    rnd_r, sat_r;
    logic signed [PW-1:0]    ax, dx, by, ey;

    function automatic logic signed [SW-1:0] ext_p(input logic signed [PW-1:0] v);
        return {{(SW-PW){v[PW-1]}}, v};
    endfunction

    function automatic logic signed [SW-1:0] ext_w(input logic signed [WIDTH-1:0] v);
        return {{(SW-WIDTH){v[WIDTH-1]}}, v};
    endfunction

    // Returns {out_of_range, value} with saturation or wrap applied.
    function automatic logic [WIDTH:0] fit(input logic signed [SW-1:0] v, input logic sat);
        logic             hi, lo;
        logic [WIDTH-1:0] r;
        hi = (v > MAX_V);
        lo = (v < MIN_V);
        r  = v[WIDTH-1:0];
        if (sat && hi)      r = {1'b0, {(WIDTH-1){1'b1}}};
        else if (sat && lo) r = {1'b1, {(WIDTH-1){1'b0}}};
        return {hi | lo, r};
    endfunction

    logic signed [SW-1:0] rnd_add, sum_x, sum_y, sh_x, sh_y;
    logic [WIDTH:0]       fx, fy;

    always_comb begin
        rnd_add = '0;
        if (rnd_r) rnd_add = {{(SW-1){1'b0}}, 1'b1} << (FRAC-1);
        // Offsets are integers: align them to the product's binary point.
        sum_x = ext_p(ax) + ext_p(by) + (ext_w(tx_r) <<< FRAC) + rnd_add;
        sum_y = ext_p(dx) + ext_p(ey) + (ext_w(ty_r) <<< FRAC) + rnd_add;
        sh_x  = sum_x >>> FRAC;
        sh_y  = sum_y >>> FRAC;
        fx    = fit(sh_x, sat_r);
        fy    = fit(sh_y, sat_r);
    end

    // ------------------------------------------------------------------
    // Engine FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            done    <= 1'b0;
            a_r     <= '0;
            b_r     <= '0;
            d_r     <= '0;
            e_r     <= '0;
            tx_r    <= '0;
            ty_r    <= '0;
            x_r     <= '0;
            y_r     <= '0;
            rnd_r   <= 1'b0;
            sat_r   <= 1'b0;
            ax      <= '0;
            dx      <= '0;
            by      <= '0;
            ey      <= '0;
            res_x   <= '0;
            res_y   <= '0;
            res_ovf <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        // Configuration is frozen for the whole point here.
                        x_r   <= in_mem_x[in_rd];
                        y_r   <= in_mem_y[in_rd];
                        a_r   <= cfg_a;
                        b_r   <= cfg_b;
                        d_r   <= cfg_d;
                        e_r   <= cfg_e;
                        tx_r  <= cfg_tx;
                        ty_r  <= cfg_ty;
                        rnd_r <= cfg_round;
                        sat_r <= cfg_sat;
                        state <= MUL1;
                    end
                end
                MUL1: begin
                    ax    <= a_r * x_r;
                    dx    <= d_r * x_r;
                    state <= MUL2;
                end
                MUL2: begin
                    by    <= b_r * y_r;
                    ey    <= e_r * y_r;
                    state <= SUM;
                end
                SUM: begin
                    res_x   <= fx[WIDTH-1:0];
                    res_y   <= fy[WIDTH-1:0];
                    res_ovf <= fx[WIDTH] | fy[WIDTH];
                    state   <= PUSH;
                end
                PUSH: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Overflow is raised when the offending result is written, so an aborted
    // point never flags it. A set beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst)                         overflow <= 1'b0;
        else if (out_push && res_ovf)    overflow <= 1'b1;
        else if (clear_ovf)              overflow <= 1'b0;
    end

    assign busy      = (state != IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_affine_stream_engine.sv
module tb_affine_stream_engine;

    localparam int W     = 16;
    localparam int FRAC  = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  cfg_a, cfg_b, cfg_d, cfg_e, cfg_tx, cfg_ty;
    logic          cfg_round, cfg_sat, enable, flush, clear_ovf;
    logic          in_valid;
    logic [W-1:0]  in_x, in_y;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_x, out_y;
    logic          out_ready;
    logic [CW-1:0] in_count, out_count;
    logic          busy, done, overflow;
    logic [2:0]    state_dbg;

    affine_stream_engine #(.WIDTH(W), .FRAC(FRAC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cfg_a(cfg_a), .cfg_b(cfg_b), .cfg_d(cfg_d), .cfg_e(cfg_e),
        .cfg_tx(cfg_tx), .cfg_ty(cfg_ty),
        .cfg_round(cfg_round), .cfg_sat(cfg_sat),
        .enable(enable), .flush(flush), .clear_ovf(clear_ovf),
        .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ready(in_ready),
        .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_ready(out_ready),
        .in_count(in_count), .out_count(out_count),
        .busy(busy), .done(done), .overflow(overflow), .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int             n_checks = 0;
    int             n_fail   = 0;
    int             done_cnt = 0;
    int             out_cnt  = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_e;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint sx(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    // One axis: exact integer arithmetic, floor division, then range handling.
    function automatic logic [W:0] model_axis(input longint c0, input longint c1,
                                              input longint t, input longint x,
                                              input longint y, input bit rnd,
                                              input bit sat);
        longint p, q, scale, maxo, mino;
        logic   ovf;
        scale = longint'(1) << FRAC;
        maxo  = (longint'(1) << (W-1)) - 1;
        mino  = -(longint'(1) << (W-1));
        p = c0*x + c1*y + t*scale;
        if (rnd) p = p + scale/2;
        q = p / scale;
        if (p < 0 && (p % scale) != 0) q = q - 1;
        ovf = (q > maxo) || (q < mino);
        if (sat && q > maxo) q = maxo;
        else if (sat && q < mino) q = mino;
        return {ovf, q[W-1:0]};
    endfunction

    function automatic logic [2*W-1:0] model_point(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0] rx, ry;
        rx = model_axis(sx(cfg_a), sx(cfg_b), sx(cfg_tx), sx(x), sx(y), cfg_round, cfg_sat);
        ry = model_axis(sx(cfg_d), sx(cfg_e), sx(cfg_ty), sx(x), sx(y), cfg_round, cfg_sat);
        return {rx[W-1:0], ry[W-1:0]};
    endfunction

    // ---------------- compare process ----------------
    // Sampled on the falling edge: the values seen here are what the next
    // rising edge will transfer.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_xy", {out_x, out_y}, mon_e);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model_point(in_x, in_y));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int a, input int b, input int d, input int e,
                           input int tx, input int ty, input bit rnd, input bit sat);
        cfg_a = W'(a); cfg_b = W'(b); cfg_d = W'(d); cfg_e = W'(e);
        cfg_tx = W'(tx); cfg_ty = W'(ty);
        cfg_round = rnd; cfg_sat = sat;
    endtask

    // Returns just after the accepting edge.
    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; in_x = x; in_y = y;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (!ok) check("send_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(input int max, output int lat);
        lat = 0;
        for (int k = 1; k <= max; k++) begin
            tick();
            if (out_valid) begin lat = k; break; end
        end
        if (lat == 0) check("wait_out_timeout", 0, 1);
    endtask

    task automatic run_point(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                             input int ex, input int ey);
        int lat;
        send(x, y);
        wait_out(20, lat);
        check({name, "_x"}, sx(out_x), ex);
        check({name, "_y"}, sx(out_y), ey);
    endtask

    task automatic check_reset(input string p);
        check({p, "_in_ready"},  in_ready, 1);
        check({p, "_out_valid"}, out_valid, 0);
        check({p, "_in_count"},  in_count, 0);
        check({p, "_out_count"}, out_count, 0);
        check({p, "_busy"},      busy, 0);
        check({p, "_done"},      done, 0);
        check({p, "_overflow"},  overflow, 0);
        check({p, "_out_x"},     out_x, 0);
        check({p, "_out_y"},     out_y, 0);
        check({p, "_state"},     state_dbg, 0);
    endtask

    // ---------------- test sequence ----------------
    int   lat, i, d0, o0;
    logic acc, ov_before;

    initial begin
        rst = 1'b1; enable = 1'b1; flush = 1'b0; clear_ovf = 1'b0;
        in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
        set_cfg(256, 0, 0, 256, 0, 0, 1'b0, 1'b0);
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Identity, latency and single done pulse
        d0 = done_cnt;
        send(16'd100, W'(-50));
        wait_out(20, lat);
        check("id_latency", lat, 5);
        check("id_x", sx(out_x), 100);
        check("id_y", sx(out_y), -50);
        check("id_done", done, 1);
        check("id_overflow", overflow, 0);
        repeat (3) tick();
        check("id_done_once", done_cnt - d0, 1);

        // Scale and offset, floor vs round
        set_cfg(128, 0, 0, 512, 10, -3, 1'b0, 1'b0);
        run_point("scale_floor", 16'd7, 16'd5, 13, 7);
        cfg_round = 1'b1;
        run_point("scale_round", 16'd7, 16'd5, 14, 7);
        set_cfg(128, 0, 0, 512, 0, 0, 1'b0, 1'b0);
        run_point("neg_floor", W'(-1), 16'd0, -1, 0);
        cfg_round = 1'b1;
        run_point("neg_round", W'(-1), 16'd0, 0, 0);

        // Overflow: saturate, wrap, clear, set-wins
        set_cfg(32767, 0, 0, 0, 0, 0, 1'b0, 1'b1);
        run_point("ovf_sat", 16'h7FFF, 16'd0, 32767, 0);
        check("ovf_sat_flag", overflow, 1);
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        cfg_sat = 1'b0;
        run_point("ovf_wrap", 16'h7FFF, 16'd0, -256, 0);
        check("ovf_wrap_flag", overflow, 1);
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        check("ovf_cleared2", overflow, 0);
        send(16'h7FFF, 16'd0);
        repeat (4) tick();
        clear_ovf = 1'b1; tick(); clear_ovf = 1'b0;
        check("ovf_set_wins", overflow, 1);
        check("ovf_set_wins_x", sx(out_x), -256);
        repeat (3) tick();

        // Backpressure
        set_cfg(256, 0, 0, 256, 0, 0, 1'b0, 1'b0);
        out_ready = 1'b0;
        o0 = out_cnt;
        i = 0;
        for (int c = 0; c < 60 && i < 10; c++) begin
            in_valid = 1'b1; in_x = W'(i*11 - 20); in_y = W'(5 - i*3);
            @(negedge clk); acc = in_ready;
            tick();
            if (acc) i++;
        end
        check("bp_accepted", i, 8);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_count", out_count, 4);
        check("bp_in_count", in_count, 4);
        check("bp_busy", busy, 0);
        out_ready = 1'b1;
        for (int c = 0; c < 100 && i < 10; c++) begin
            in_valid = 1'b1; in_x = W'(i*11 - 20); in_y = W'(5 - i*3);
            @(negedge clk); acc = in_ready;
            tick();
            if (acc) i++;
        end
        in_valid = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("bp_drained", exp_q.size(), 0);
        check("bp_emitted", out_cnt - o0, 10);

        // Flush while in MUL2 with three points still queued
        ov_before = overflow;
        enable = 1'b0;
        send(16'd1, 16'd2); send(16'd3, 16'd4); send(16'd5, 16'd6); send(16'd7, 16'd8);
        check("fl_in_count_pre", in_count, 4);
        enable = 1'b1;
        tick(); tick();
        check("fl_busy_pre", busy, 1);
        check("fl_queued", in_count, 3);
        flush = 1'b1; in_valid = 1'b1; in_x = 16'd999; in_y = 16'd999;
        d0 = done_cnt;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_in_count", in_count, 0);
        check("fl_out_count", out_count, 0);
        check("fl_busy", busy, 0);
        check("fl_done", done, 0);
        check("fl_out_valid", out_valid, 0);
        check("fl_overflow", overflow, ov_before);
        repeat (8) tick();
        check("fl_no_done", done_cnt - d0, 0);
        run_point("fl_after", 16'd33, W'(-44), 33, -44);
        repeat (2) tick();

        // Reset in SUM with both FIFOs non-empty
        out_ready = 1'b0;
        send(16'd1, 16'd2);
        wait_out(20, lat);
        enable = 1'b0;
        send(16'd3, 16'd4); send(16'd5, 16'd6);
        enable = 1'b1;
        tick(); tick(); tick();
        check("rs_in_count_pre", in_count, 1);
        check("rs_out_count_pre", out_count, 1);
        rst = 1'b1;
        tick();
        check_reset("rs");
        rst = 1'b0;
        out_ready = 1'b1;
        o0 = out_cnt; d0 = done_cnt;
        repeat (10) tick();
        check("rs_no_output", out_cnt - o0, 0);
        check("rs_no_done", done_cnt - d0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/affine_stream_engine.md
Name: affine_stream_engine

Overview:
Streaming 2-D affine transform engine, parametrised in width and fixed-point format: out_x = a*x + b*y + tx, out_y = d*x + e*y + ty. Points enter through a valid/ready input FIFO and results leave through a valid/ready output FIFO. Adds batch operation, selectable rounding/saturation, a sticky overflow flag and flush. Sits behind the peripheral register wrapper, which drives cfg_* and maps the FIFO ports onto the bus.

Parameters:
WIDTH, 16, signed width of coefficients, offsets, inputs and outputs
FRAC, 8, fractional bits of a/b/d/e (Q(WIDTH-FRAC).FRAC); 1 <= FRAC < WIDTH
DEPTH, 4, entries per FIFO; power of 2, >= 2

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_a, cfg_b, cfg_d, cfg_e  in  WIDTH each  signed matrix coefficients, Q.FRAC
cfg_tx, cfg_ty  in  WIDTH each  signed integer offsets
cfg_round  in  1  1 = round-half-up, 0 = floor (arithmetic shift)
cfg_sat  in  1  1 = saturate, 0 = wrap (keep low WIDTH bits)
enable  in  1  allows the engine to pop new points
flush  in  1  single-cycle pulse: empty both FIFOs and abort the in-flight point
clear_ovf  in  1  clears the overflow flag
in_valid, in_x, in_y  in  1/WIDTH/WIDTH  input point
in_ready  out  1  equals !input_fifo_full
out_valid  out  1  equals !output_fifo_empty
out_x, out_y  out  WIDTH each  head of the output FIFO
out_ready  in  1  consumer accepts the head entry
in_count, out_count  out  $clog2(DEPTH+1) each  FIFO occupancy
busy  out  1  state != IDLE
done  out  1  one-cycle pulse when a result is written to the output FIFO
overflow  out  1  sticky flag: a result exceeded the WIDTH range

Behaviour:
- Reset: FSM to IDLE; both FIFOs empty; in_ready=1, out_valid=0, counts=0, busy=0, done=0, overflow=0. out_x/out_y read 0 while empty.
- FIFO push on in_valid&in_ready; pop on out_valid&out_ready. Pointers wrap modulo DEPTH. Simultaneous push and pop keep the count unchanged.
- FSM states: IDLE, MUL1, MUL2, SUM, PUSH.
  - IDLE -> MUL1 when enable & in_count>0 & out_count<DEPTH. At that edge: pop the input FIFO, latch x and y, and snapshot all cfg_* inputs.
  - MUL1: register ax and dx (2*WIDTH-bit signed products). -> MUL2.
  - MUL2: register by and ey. -> SUM.
  - SUM: s = ax + by + (tx <<< FRAC), computed at 2*WIDTH+2 bits with sign extension. Add 2^(FRAC-1) if round. Arithmetic shift right by FRAC. Register the result. Y is computed the same way with dx, ey, ty. -> PUSH.
  - PUSH: write {x,y} to the output FIFO and pulse done. -> IDLE.
- Range handling: if the shifted value lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1] for x or y, set overflow. If cfg_sat=1, clamp to the bound; otherwise truncate to the low WIDTH bits.
- Overflow flag: cleared only by clear_ovf or rst. If a set and clear_ovf fall in the same cycle, the set wins.
- Latency: result visible (out_valid=1) 5 clocks after the input handshake edge, when idle with empty FIFOs. Throughput is 1 point per 5 clocks.
- Output space is reserved at pop (out_count<DEPTH with a single point in flight), so PUSH never meets a full FIFO.
- A mid-point change to cfg_* has no effect on that point; the next point uses the new values.
- enable deasserted mid-point: the current point completes, then no further pops.
- flush: next edge empties both FIFOs and forces IDLE with no PUSH and no done. overflow is unchanged. An in_valid or out_ready in the same cycle is ignored.
- rst mid-operation: full reset as above. rst has priority over flush.
- Output order equals input order.

Test Plan:
- Identity: a=e=256, b=d=tx=ty=0, x=100, y=-50 -> out (100,-50); out_valid high 5 clocks after the accept edge; done pulses once; overflow=0.
- Scale/offset: a=128, e=512, b=d=0, tx=10, ty=-3, x=7, y=5. Floor mode -> (13,7); round mode -> (14,7). x=-1 (a=128, tx=0): floor -> -1, round -> 0.
- Overflow: a=0x7FFF, x=0x7FFF, all other coefficients 0. sat=1 -> out_x=32767; sat=0 -> out_x=-256 (0xFF00). overflow=1 in both cases. clear_ovf -> 0, but stays 1 if another overflow lands in the same cycle.
- Backpressure: DEPTH=4, out_ready=0, offer 10 points -> exactly 8 accepted, then in_ready=0, out_count=4, in_count=4, busy=0. Raise out_ready -> all 10 points emerge in order with correct values.
- Flush in MUL2 with 3 points queued -> next cycle: counts=0, busy=0, no done, overflow unchanged; a new point afterwards completes normally.
- rst asserted in SUM with both FIFOs non-empty -> all outputs at reset values the following cycle; nothing is emitted.
